// File: rtl/norm_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : norm_stream_sched
// Brief    : Frame-synchronous scheduler for the integer x fraction pixel
//            normalizer: SOF-aligned config, frame length check, 2-stage pipe.
// Revision : 1.0 - initial release
// ============================================================================
module norm_stream_sched #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,   // must be >= OUT_WIDTH
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 24,
    parameter logic [FRAC_WIDTH-1:0] RESET_NORM = '1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [FRAC_WIDTH-1:0] cfg_norm,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [INT_WIDTH-1:0]  s_data,
    input  logic                  s_sof,
    input  logic                  s_eof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  len_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_done
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int                 c_prod_w    = INT_WIDTH + FRAC_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [FRAC_WIDTH-1:0] norm_act_q, norm_act_d;
    logic [CNT_WIDTH-1:0]  len_act_q, len_act_d;
    logic [FRAC_WIDTH-1:0] norm_sh_q, norm_sh_d;
    logic [CNT_WIDTH-1:0]  len_sh_q, len_sh_d;
    logic                  pend_q, pend_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  frames_q, frames_d;
    logic                  len_err_q, len_err_d;

    logic                  s1_valid_q;
    logic [INT_WIDTH-1:0]  s1_pix_q;
    logic [FRAC_WIDTH-1:0] s1_fac_q;
    logic                  s1_sof_q, s1_eof_q;
    logic                  s2_valid_q;
    logic [OUT_WIDTH-1:0]  s2_data_q;
    logic                  s2_sof_q, s2_eof_q;

    logic                  w_s1_ready, w_s2_ready;
    logic                  w_s_acc, w_sof_acc, w_fwd, w_cfg_xfer, w_apply;
    logic [FRAC_WIDTH-1:0] w_norm_frame;
    logic [CNT_WIDTH-1:0]  w_len_frame, w_cnt_inc;
    logic                  w_len_bad1;
    logic [c_prod_w-1:0]   w_prod;
    logic [OUT_WIDTH-1:0]  w_prod_sel;

    assign w_s2_ready = !s2_valid_q || m_ready;
    assign w_s1_ready = !s1_valid_q || w_s2_ready;
    assign w_s_acc    = s_valid && w_s1_ready;
    assign w_sof_acc  = w_s_acc && s_sof;
    assign w_fwd      = w_s_acc && (s_sof || (state_q == ST_ACTIVE));
    assign w_cfg_xfer = cfg_valid && !pend_q;
    assign w_apply    = w_sof_acc && pend_q;

    // The SOF beat that applies a pending config already uses the new values.
    assign w_norm_frame = w_apply ? norm_sh_q : norm_act_q;
    assign w_len_frame  = w_apply ? len_sh_q  : len_act_q;
    assign w_len_bad1   = (w_len_frame != '0) && (w_len_frame != c_cnt_one);
    assign w_cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + c_cnt_one;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frames_d   = frames_q;
        len_err_d  = 1'b0;
        norm_act_d = norm_act_q;
        len_act_d  = len_act_q;
        norm_sh_d  = norm_sh_q;
        len_sh_d   = len_sh_q;
        pend_d     = pend_q;

        if (w_cfg_xfer) begin
            norm_sh_d = cfg_norm;
            len_sh_d  = cfg_frame_len;
            pend_d    = 1'b1;
        end else if (w_apply) begin
            pend_d = 1'b0;
        end
        if (w_apply) begin
            norm_act_d = norm_sh_q;
            len_act_d  = len_sh_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_sof_acc) begin
                    cnt_d = c_cnt_one;
                    if (s_eof) begin
                        frames_d  = frames_q + c_cnt_one;
                        len_err_d = w_len_bad1;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_s_acc) begin
                    if (s_sof) begin
                        // Truncated frame: flagged against the old length, not counted.
                        cnt_d     = c_cnt_one;
                        len_err_d = (len_act_q != '0);
                        if (s_eof) begin
                            frames_d  = frames_q + c_cnt_one;
                            len_err_d = (len_act_q != '0) || w_len_bad1;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        cnt_d = w_cnt_inc;
                        if (s_eof) begin
                            frames_d  = frames_q + c_cnt_one;
                            len_err_d = (len_act_q != '0) && (w_cnt_inc != len_act_q);
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            norm_act_q <= RESET_NORM;
            len_act_q  <= '0;
            norm_sh_q  <= '0;
            len_sh_q   <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            frames_q   <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            norm_act_q <= norm_act_d;
            len_act_q  <= len_act_d;
            norm_sh_q  <= norm_sh_d;
            len_sh_q   <= len_sh_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            frames_q   <= frames_d;
            len_err_q  <= len_err_d;
        end
    end

    // Keep product bits [FRAC_WIDTH-1 : FRAC_WIDTH-OUT_WIDTH], no rounding.
    assign w_prod     = {{FRAC_WIDTH{1'b0}}, s1_pix_q} * {{INT_WIDTH{1'b0}}, s1_fac_q};
    assign w_prod_sel = OUT_WIDTH'(w_prod >> (FRAC_WIDTH - OUT_WIDTH));

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_fac_q   <= '0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sof_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
        end else begin
            if (w_s1_ready) begin
                s1_valid_q <= w_fwd;
                if (w_fwd) begin
                    s1_pix_q <= s_data;
                    s1_fac_q <= w_norm_frame;
                    s1_sof_q <= s_sof;
                    s1_eof_q <= s_eof;
                end
            end
            if (w_s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= w_prod_sel;
                    s2_sof_q  <= s1_sof_q;
                    s2_eof_q  <= s1_eof_q;
                end
            end
        end
    end

    assign cfg_ready   = !pend_q;
    assign s_ready     = w_s1_ready;
    assign m_valid     = s2_valid_q;
    assign m_data      = s2_data_q;
    assign m_sof       = s2_sof_q;
    assign m_eof       = s2_eof_q;
    assign len_err     = len_err_q;
    assign busy        = (state_q == ST_ACTIVE) || s1_valid_q || s2_valid_q;
    assign frames_done = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_norm_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_stream_sched
// Brief    : Directed self-checking bench for norm_stream_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_stream_sched;

    localparam int INT_WIDTH  = 8;
    localparam int FRAC_WIDTH = 8;
    localparam int OUT_WIDTH  = 8;
    localparam int CNT_WIDTH  = 24;

    logic                  clk = 1'b0;
    logic                  srst;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [FRAC_WIDTH-1:0] cfg_norm;
    logic [CNT_WIDTH-1:0]  cfg_frame_len;
    logic                  s_valid;
    logic                  s_ready;
    logic [INT_WIDTH-1:0]  s_data;
    logic                  s_sof;
    logic                  s_eof;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_WIDTH-1:0]  m_data;
    logic                  m_sof;
    logic                  m_eof;
    logic                  len_err;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  frames_done;

    norm_stream_sched #(
        .INT_WIDTH  (INT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .RESET_NORM ({FRAC_WIDTH{1'b1}})
    ) u_dut (
        .clk           (clk),
        .srst          (srst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_norm      (cfg_norm),
        .cfg_frame_len (cfg_frame_len),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .s_eof         (s_eof),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_sof         (m_sof),
        .m_eof         (m_eof),
        .len_err       (len_err),
        .busy          (busy),
        .frames_done   (frames_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_cnt  = 0;
    logic [9:0]  out_q[$];
    logic        bp_phase  = 1'b0;
    logic        saw_full  = 1'b0;
    logic        stall_prev = 1'b0;
    logic [9:0]  held;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    // Output beats are captured like a flop: values seen just before the edge.
    always @(posedge clk) begin
        if (len_err) err_cnt++;
        if (!srst && m_valid && m_ready) out_q.push_back({m_sof, m_eof, m_data});
        if (bp_phase && stall_prev)
            chk("stall_hold", {22'd0, m_valid, m_sof, m_eof, m_data}, {22'd0, 1'b1, held});
        if (bp_phase && s_valid && !s_ready) saw_full = 1'b1;
        stall_prev = !srst && m_valid && !m_ready;
        held       = {m_sof, m_eof, m_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic eof);
        int   n;
        logic acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eof   = eof;
        do begin
            #2;
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eof   = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] norm, input logic [CNT_WIDTH-1:0] len);
        int   n;
        logic acc;
        n = 0;
        cfg_valid     = 1'b1;
        cfg_norm      = norm;
        cfg_frame_len = len;
        do begin
            #2;
            acc = cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("cfg_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) chk("drain_timeout", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [9:0] exp);
        logic [31:0] v;
        if (out_q.size() == 0) v = 32'hDEAD_0000;
        else v = {22'd0, out_q.pop_front()};
        chk(tag, v, {22'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [19:0] pat;
    logic [7:0]  pix;
    logic [15:0] prod;
    int          e0;

    initial begin
        srst = 1'b1; cfg_valid = 1'b0; cfg_norm = '0; cfg_frame_len = '0;
        s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eof = 1'b0; m_ready = 1'b1;
        repeat (3) tick();
        srst = 1'b0;
        tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_len_err", len_err, 0);

        // Basic frame: 2,2,3,0 with factor 0x90.
        cfg(8'h90, 4);
        send(8'd2, 1'b1, 1'b0);
        chk("lat_early", m_valid, 0);
        tick();
        chk("lat_valid", m_valid, 1);
        chk("lat_data", m_data, 8'h20);
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        send(8'd0, 1'b0, 1'b1);
        drain();
        pop_chk("basic0", {2'b10, 8'h20});
        pop_chk("basic1", {2'b00, 8'h20});
        pop_chk("basic2", {2'b00, 8'hB0});
        pop_chk("basic3", {2'b01, 8'h00});
        chk("basic_frames", frames_done, 1);
        chk("basic_err", err_cnt, 0);

        // Config offered alongside SOF while another one is still pending.
        cfg(8'h55, 0);
        chk("cfg_pending", cfg_ready, 0);
        cfg_valid = 1'b1; cfg_norm = 8'h01; cfg_frame_len = 0;
        s_valid = 1'b1; s_data = 8'd3; s_sof = 1'b1; s_eof = 1'b0;
        chk("cfg_blocked_at_sof", cfg_ready, 0);
        tick();
        chk("cfg_free_after_sof", cfg_ready, 1);
        s_sof = 1'b0; s_eof = 1'b1;
        tick();
        cfg_valid = 1'b0; s_valid = 1'b0; s_eof = 1'b0;
        chk("cfg_new_pending", cfg_ready, 0);
        drain();
        send(8'd3, 1'b1, 1'b1);
        drain();
        pop_chk("cfgA0", {2'b10, 8'hFF});
        pop_chk("cfgA1", {2'b01, 8'hFF});
        pop_chk("cfgB0", {2'b11, 8'h03});
        chk("cfg_frames", frames_done, 3);
        chk("cfg_applied", cfg_ready, 1);

        // Backpressure: 16 beats against a fixed m_ready pattern.
        cfg(8'h90, 16);
        pat = 20'b1100_1101_0110_0000_1011;
        bp_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'(i * 13 + 5), i == 0, i == 15);
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    @(posedge clk);
                    #2;
                    m_ready = (k < 20) ? pat[k] : 1'b1;
                end
            end
        join
        m_ready = 1'b1;
        drain();
        bp_phase = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix  = 8'(i * 13 + 5);
            prod = pix * 8'h90;
            pop_chk("bp_beat", {(i == 0), (i == 15), prod[7:0]});
        end
        chk("bp_s_ready_drop", saw_full, 1);
        chk("bp_frames", frames_done, 4);
        chk("bp_err", err_cnt, 0);

        // Length errors: short frame, then a frame truncated by a new SOF.
        cfg(8'h90, 4);
        send(8'd1, 1'b1, 1'b0);
        send(8'd1, 1'b0, 1'b0);
        send(8'd1, 1'b0, 1'b1);
        drain();
        chk("short_err", err_cnt, 1);
        chk("short_frames", frames_done, 5);
        chk("short_beats", out_q.size(), 3);
        out_q.delete();
        send(8'd1, 1'b1, 1'b0);
        send(8'd1, 1'b0, 1'b0);
        send(8'd1, 1'b1, 1'b0);
        tick();
        tick();
        chk("trunc_err", err_cnt, 2);
        chk("trunc_frames", frames_done, 5);
        chk("trunc_active", busy, 1);
        send(8'd1, 1'b0, 1'b1);
        drain();
        chk("trunc_close_err", err_cnt, 3);
        chk("trunc_close_frames", frames_done, 6);
        chk("trunc_beats", out_q.size(), 4);
        out_q.delete();

        // Discard in IDLE, then a one-beat frame.
        for (int i = 0; i < 3; i++) begin
            send(8'd7, 1'b0, 1'b0);
            chk("disc_busy", busy, 0);
            chk("disc_m_valid", m_valid, 0);
        end
        tick();
        tick();
        chk("disc_no_out", out_q.size(), 0);
        send(8'd2, 1'b1, 1'b1);
        drain();
        pop_chk("single_beat", {2'b11, 8'h20});
        chk("single_frames", frames_done, 7);
        chk("single_err", err_cnt, 4);
        chk("single_idle", busy, 0);

        // Reset with both stages full and a config pending.
        cfg(8'h22, 0);
        m_ready = 1'b0;
        send(8'd1, 1'b1, 1'b0);
        send(8'd1, 1'b0, 1'b0);
        chk("full_s_ready", s_ready, 0);
        chk("full_m_valid", m_valid, 1);
        e0 = err_cnt;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        chk("mid_rst_frames", frames_done, 0);
        chk("mid_rst_busy", busy, 0);
        m_ready = 1'b1;
        tick();
        tick();
        chk("mid_rst_no_err", err_cnt, e0);
        send(8'd1, 1'b1, 1'b1);
        drain();
        pop_chk("rst_norm", {2'b11, 8'hFF});
        chk("post_rst_frames", frames_done, 1);
        chk("post_rst_err", err_cnt, e0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
